// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I)
// and load/store (D); the granted request is registered and held until m_ready.
//
// state | meaning
// IDLE  | no transaction; arbitrate pending requests
// BUSY  | m_req high, m_* frozen, waiting for m_ready
// DONE  | owner's valid pulse is high; return to IDLE
module mem_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_valid,
  input  logic             d_req,
  input  logic [WIDTH-1:0] d_addr,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_valid,
  output logic             m_req,
  output logic [WIDTH-1:0] m_addr,
  output logic             m_we,
  output logic [WIDTH-1:0] m_wdata,
  input  logic             m_ready,
  input  logic [WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             m_req_d;
  logic [WIDTH-1:0] m_addr_d;
  logic             m_we_d;
  logic [WIDTH-1:0] m_wdata_d;
  logic             i_valid_d, d_valid_d;
  logic [WIDTH-1:0] i_rdata_d, d_rdata_d;
  logic             grant_i, grant_d;

  // I wins unless D is also pending and I was the previous owner.
  assign grant_i = i_req && (!d_req || (last_q == OWN_D));
  assign grant_d = d_req && !grant_i;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    m_req_d   = m_req;
    m_addr_d  = m_addr;
    m_we_d    = m_we;
    m_wdata_d = m_wdata;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          m_addr_d  = i_addr;
          m_we_d    = 1'b0;
          m_wdata_d = '0;
          m_req_d   = 1'b1;
          owner_d   = OWN_I;
          last_d    = OWN_I;
          state_d   = BUSY;
        end else if (grant_d) begin
          m_addr_d  = d_addr;
          m_we_d    = d_we;
          m_wdata_d = d_wdata;
          m_req_d   = 1'b1;
          owner_d   = OWN_D;
          last_d    = OWN_D;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          state_d = DONE;
          if (owner_q == OWN_I) begin
            i_rdata_d = m_rdata;
            i_valid_d = 1'b1;
          end else begin
            d_rdata_d = m_rdata;
            d_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        // No arbitration here: the owner's req may still be high this cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= OWN_D;
      owner_q <= OWN_I;
      m_req   <= 1'b0;
      m_addr  <= '0;
      m_we    <= 1'b0;
      m_wdata <= '0;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      m_req   <= m_req_d;
      m_addr  <= m_addr_d;
      m_we    <= m_we_d;
      m_wdata <= m_wdata_d;
      i_valid <= i_valid_d;
      d_valid <= d_valid_d;
      i_rdata <= i_rdata_d;
      d_rdata <= d_rdata_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (I) and the load/store requester (D) of the 32-bit RISC-V core.
- Arbitrates round-robin and registers the winning request onto the memory port through its internal select, which is held stable for the whole transaction.
- Runs a variable-latency req/ready handshake and returns read data to the granted requester with a one-cycle valid pulse.
- Sits between the fetch/LSU stages and the memory wrapper.

Parameters:
- WIDTH, 32, data and address width in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; level, held high with i_addr stable until i_valid.
- i_addr  in  WIDTH  fetch address.
- i_rdata  out  WIDTH  fetched word; valid only while i_valid is high.
- i_valid  out  1  one-cycle completion pulse to fetch.
- d_req  in  1  load/store request; level, held high with d_addr/d_we/d_wdata stable until d_valid.
- d_addr  in  WIDTH  data address.
- d_we  in  1  1 = store, 0 = load.
- d_wdata  in  WIDTH  store data.
- d_rdata  out  WIDTH  load data; valid only while d_valid is high.
- d_valid  out  1  one-cycle completion pulse to LSU, for loads and stores.
- m_req  out  1  memory request; held high until m_ready is sampled high.
- m_addr  out  WIDTH  registered address of the granted requester.
- m_we  out  1  registered write enable; forced 0 for I grants.
- m_wdata  out  WIDTH  registered store data; 0 for I grants.
- m_ready  in  1  memory completion, sampled only while m_req is high.
- m_rdata  in  WIDTH  read data, valid in the cycle m_ready is high.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, last_grant = D (so I wins the first tie).
  - m_req = 0, m_we = 0, m_addr = 0, m_wdata = 0.
  - i_valid = 0, d_valid = 0, i_rdata = 0, d_rdata = 0.
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Only one request pending: grant it.
  - Both pending: grant the requester that is not last_grant.
  - On a grant: latch the granted addr/we/wdata (I grant forces we = 0 and wdata = 0) into the m_* registers, set m_req = 1, record owner and last_grant, go to BUSY.
- BUSY:
  - m_req stays high and the m_* registers stay frozen.
  - Requester inputs are ignored, including the owner changing or dropping its req.
  - m_ready = 1: clear m_req, capture m_rdata into the owner's rdata register, pulse the owner's valid, go to DONE.
  - The non-owner rdata register holds its previous value.
- DONE:
  - valid is high for exactly this cycle; go to IDLE next cycle.
  - No arbitration in DONE. The owner must drop its req, or present a new request, in the DONE cycle, so no double grant is possible.
- Latency:
  - Grant edge at cycle 0.
  - m_req high from cycle 1.
  - m_ready seen in cycle k (k ≥ 1) gives valid in cycle k+1.
  - Minimum request-to-valid latency is 2 cycles. Back-to-back grants are at best 3 cycles apart.
- Simultaneous events: when i_req and d_req rise in the same IDLE cycle, round-robin decides. A requester that is continuously pending is granted within one other transaction.
- A request arriving during BUSY or DONE waits for IDLE. No requests are dropped or queued beyond the level-held req.
- m_ready while m_req = 0 is ignored.
- Reset mid-transaction: all state and outputs return to reset values immediately. The in-flight memory response is discarded and no valid pulse is issued.
- Stores: d_rdata is loaded with m_rdata regardless of d_we. The value is don't-care for the LSU.

Test Plan:
- I-only read: i_req = 1, i_addr = 0x0000_0040; memory returns 0x0050_0093 with m_ready two cycles after m_req -> m_addr = 0x40, m_we = 0, then i_rdata = 0x0050_0093 with a single i_valid pulse; d_valid stays 0.
- Simultaneous requests after reset: i_req = d_req = 1, d_addr = 0x1000, d_we = 1, d_wdata = 0xDEAD_BEEF, zero-wait memory -> I granted first (m_addr = I addr, m_we = 0), i_valid, then D granted 3 cycles after the first grant with m_we = 1 and m_wdata = 0xDEAD_BEEF, then d_valid.
- Fairness: both reqs held high for 6 transactions -> grant order is I, D, I, D, I, D.
- Stall: m_ready held low for 10 cycles -> m_req, m_addr, m_we and m_wdata are stable for all 10 cycles; d_addr changing during BUSY has no effect on m_addr.
- Reset mid-BUSY: reset_n low for one cycle while m_req = 1 -> m_req = 0 and state IDLE immediately; the subsequent m_ready = 1 produces no valid pulse.
- Spurious ready: m_ready = 1 in IDLE with no requests -> no valid pulse and no state change.
